// File: rtl/d_write_buffer_pkg.sv
// Shared memory-path definitions for the d-cache, the write buffer and the
// AXI bridge: drain FSM state encodings, the posted-write entry layout and
// small state-decoding helpers.
package d_write_buffer_pkg;

    // Drain FSM state encodings (3-bit)
    localparam logic [2:0] WB_ST_IDLE  = 3'd0;
    localparam logic [2:0] WB_ST_WREQ  = 3'd1;
    localparam logic [2:0] WB_ST_WWAIT = 3'd2;
    localparam logic [2:0] WB_ST_RREQ  = 3'd3;
    localparam logic [2:0] WB_ST_RWAIT = 3'd4;

    // Posted-write entry layout: {size, addr, wdata}
    localparam int WB_SIZE_W  = 2;
    localparam int WB_AW      = 32;
    localparam int WB_ENTRY_W = WB_SIZE_W + 2 * WB_AW;  // 66

    // True while a downstream read is being issued or awaited
    function automatic logic wb_is_read_state(input logic [2:0] st);
        return (st == WB_ST_RREQ) || (st == WB_ST_RWAIT);
    endfunction

endpackage

// File: rtl/d_write_buffer_wbuf_fifo.sv
// wbuf_fifo: posted-write storage for d_write_buffer.
// Circular buffer of DEPTH entries of W bits with wrap-around pointers.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset (control only)
//   i_push, i_wdata    write an entry at the tail (ignored when full)
//   i_pop              drop the head entry (ignored when empty)
//   o_head             current head entry
//   o_full, o_empty    derived from the registered occupancy count
module wbuf_fifo
    import d_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = WB_ENTRY_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr];

    // Storage array: data only, deliberately left without reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; simultaneous push+pop leaves the count unchanged
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/d_write_buffer.sv
// d_write_buffer: posted-write buffer between the d-cache (sram-like
// upstream) and the AXI bridge (sram-like downstream).
// Writes are acknowledged one cycle after acceptance and drained in order;
// reads wait until every buffered write has completed downstream and are
// then passed straight through. One downstream transaction at a time.
// Ports:
//   clk, resetn                         clock, async active-low reset
//   up_req/up_wr/up_size/up_addr/up_wdata   request from the d-cache
//   up_rdata/up_addr_ok/up_data_ok          response to the d-cache
//   dn_req/dn_wr/dn_size/dn_addr/dn_wdata   request to the AXI bridge
//   dn_rdata/dn_addr_ok/dn_data_ok          response from the AXI bridge
module d_write_buffer
    import d_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          up_req,
    input  logic          up_wr,
    input  logic [1:0]    up_size,
    input  logic [AW-1:0] up_addr,
    input  logic [AW-1:0] up_wdata,
    output logic [AW-1:0] up_rdata,
    output logic          up_addr_ok,
    output logic          up_data_ok,
    output logic          dn_req,
    output logic          dn_wr,
    output logic [1:0]    dn_size,
    output logic [AW-1:0] dn_addr,
    output logic [AW-1:0] dn_wdata,
    input  logic [AW-1:0] dn_rdata,
    input  logic          dn_addr_ok,
    input  logic          dn_data_ok
);

    localparam int ENTRY_W = WB_SIZE_W + 2 * AW;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_wr_ack;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_req;
    logic               w_rd_data_ok;
    logic [ENTRY_W-1:0] w_head;

    assign w_rd_req   = up_req & ~up_wr;
    assign w_push     = up_req & up_wr & up_addr_ok;
    assign w_pop      = (r_state == WB_ST_WWAIT) & dn_data_ok;
    assign up_data_ok = r_wr_ack | w_rd_data_ok;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_wdata ({up_size, up_addr, up_wdata}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Upstream acceptance. The reset gate matters because the count clears
    // asynchronously, which would otherwise advertise free space in reset.
    always_comb begin
        if (!resetn) begin
            up_addr_ok = 1'b0;
        end else if (up_wr) begin
            up_addr_ok = ~w_full & ~wb_is_read_state(r_state);
        end else if (r_state == WB_ST_RREQ) begin
            up_addr_ok = dn_addr_ok;
        end else begin
            up_addr_ok = 1'b0;
        end
    end

    // Drain FSM next state; buffered writes always win over a new read
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = WB_ST_WREQ;
                end else if (w_rd_req) begin
                    w_state_nxt = WB_ST_RREQ;
                end else begin
                    w_state_nxt = WB_ST_IDLE;
                end
            end
            WB_ST_WREQ: begin
                if (dn_addr_ok) begin
                    w_state_nxt = WB_ST_WWAIT;
                end else begin
                    w_state_nxt = WB_ST_WREQ;
                end
            end
            WB_ST_WWAIT: begin
                if (dn_data_ok) begin
                    w_state_nxt = WB_ST_IDLE;
                end else begin
                    w_state_nxt = WB_ST_WWAIT;
                end
            end
            WB_ST_RREQ: begin
                if (!w_rd_req) begin
                    w_state_nxt = WB_ST_IDLE;
                end else if (dn_addr_ok) begin
                    w_state_nxt = WB_ST_RWAIT;
                end else begin
                    w_state_nxt = WB_ST_RREQ;
                end
            end
            WB_ST_RWAIT: begin
                if (dn_data_ok) begin
                    w_state_nxt = WB_ST_IDLE;
                end else begin
                    w_state_nxt = WB_ST_RWAIT;
                end
            end
            default: w_state_nxt = WB_ST_IDLE;
        endcase
    end

    // FSM state and the posted-write acknowledge register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= WB_ST_IDLE;
            r_wr_ack <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ack <= w_push;
        end
    end

    // Downstream request and read-response steering by state
    always_comb begin
        dn_req       = 1'b0;
        dn_wr        = 1'b0;
        dn_size      = 2'b00;
        dn_addr      = {AW{1'b0}};
        dn_wdata     = {AW{1'b0}};
        up_rdata     = {AW{1'b0}};
        w_rd_data_ok = 1'b0;
        case (r_state)
            WB_ST_WREQ: begin
                dn_req   = 1'b1;
                dn_wr    = 1'b1;
                dn_size  = w_head[ENTRY_W-1 -: WB_SIZE_W];
                dn_addr  = w_head[2*AW-1 -: AW];
                dn_wdata = w_head[AW-1:0];
            end
            WB_ST_WWAIT: begin
                dn_size  = w_head[ENTRY_W-1 -: WB_SIZE_W];
                dn_addr  = w_head[2*AW-1 -: AW];
                dn_wdata = w_head[AW-1:0];
            end
            WB_ST_RREQ: begin
                dn_req  = w_rd_req;
                dn_size = up_size;
                dn_addr = up_addr;
            end
            WB_ST_RWAIT: begin
                up_rdata     = dn_rdata;
                w_rd_data_ok = dn_data_ok;
            end
            default: begin
                dn_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_d_write_buffer.sv
// Self-checking bench for d_write_buffer: a queue-based transaction model,
// a latency-randomised downstream responder, directed scenarios and a
// randomised upstream traffic phase.
module tb_d_write_buffer;
    import d_write_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        up_req, up_wr;
    logic [1:0]  up_size;
    logic [31:0] up_addr, up_wdata, up_rdata;
    logic        up_addr_ok, up_data_ok;
    logic        dn_req, dn_wr;
    logic [1:0]  dn_size;
    logic [31:0] dn_addr, dn_wdata, dn_rdata;
    logic        dn_addr_ok, dn_data_ok;

    always #5 clk = ~clk;

    d_write_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk(clk), .resetn(resetn),
        .up_req(up_req), .up_wr(up_wr), .up_size(up_size), .up_addr(up_addr),
        .up_wdata(up_wdata), .up_rdata(up_rdata), .up_addr_ok(up_addr_ok),
        .up_data_ok(up_data_ok),
        .dn_req(dn_req), .dn_wr(dn_wr), .dn_size(dn_size), .dn_addr(dn_addr),
        .dn_wdata(dn_wdata), .dn_rdata(dn_rdata), .dn_addr_ok(dn_addr_ok),
        .dn_data_ok(dn_data_ok)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { logic wr; logic [1:0] s; logic [31:0] a; logic [31:0] d; } txn_t;
    typedef enum { M_FREE, M_WPRES, M_WWAIT, M_RPRES, M_RWAIT } mode_e;

    // model: pending posted writes, what the engine is doing, pending write ack
    txn_t  wq[$];
    mode_e m_mode;
    bit    m_ack;

    // logs of accepted upstream writes and downstream transactions
    txn_t up_log[$];
    txn_t dn_log[$];

    // downstream responder
    bit s_busy, s_kwr, s_block, s_stray, s_rfix_en;
    int s_cnt, s_aok_pct, s_lat_min, s_lat_max, s_stray_pct;
    logic [31:0] s_rfix;
    int wdone;

    // samples taken mid-cycle
    logic smp_up_req, smp_up_wr, smp_dn_addr_ok, smp_dn_data_ok, smp_e_aok;
    logic [1:0] smp_up_size;
    logic [31:0] smp_up_addr, smp_up_wdata, smp_up_rdata, smp_dn_addr, smp_dn_wdata;
    logic smp_up_addr_ok, smp_up_data_ok, smp_dn_req, smp_dn_wr;
    logic [1:0] smp_dn_size;

    // upstream random driver
    bit u_has, u_wr, u_wait;
    int u_wt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        m_mode = M_FREE;
        m_ack  = 1'b0;
        s_busy = 1'b0;
        s_cnt  = 0;
        u_has  = 1'b0;
        u_wait = 1'b0;
    endtask

    task automatic slave_drive();
        dn_data_ok = (s_busy && s_cnt == 0) ||
                     (!s_busy && (s_stray || ($urandom_range(0, 99) < s_stray_pct)));
        dn_addr_ok = !s_busy && !s_block && ($urandom_range(0, 99) < s_aok_pct);
        dn_rdata   = s_rfix_en ? s_rfix : $urandom;
    endtask

    task automatic check_outputs();
        logic e_aok, e_dok, e_req;
        logic [31:0] e_rd;
        if (up_wr) e_aok = (m_mode != M_RPRES) && (m_mode != M_RWAIT) && (wq.size() < DEPTH);
        else       e_aok = (m_mode == M_RPRES) ? dn_addr_ok : 1'b0;
        e_dok = m_ack || (m_mode == M_RWAIT && dn_data_ok);
        e_rd  = (m_mode == M_RWAIT) ? dn_rdata : 32'h0;
        e_req = (m_mode == M_WPRES) || (m_mode == M_RPRES && up_req && !up_wr);
        chk("up_addr_ok", up_addr_ok, e_aok);
        chk("up_data_ok", up_data_ok, e_dok);
        chk("up_rdata", up_rdata, e_rd);
        chk("dn_req", dn_req, e_req);
        if (e_req && dn_req) begin
            if (m_mode == M_WPRES && wq.size() > 0) begin
                chk("dn_wr_w", dn_wr, 1'b1);
                chk("dn_size_w", dn_size, wq[0].s);
                chk("dn_addr_w", dn_addr, wq[0].a);
                chk("dn_wdata_w", dn_wdata, wq[0].d);
            end else begin
                chk("dn_wr_r", dn_wr, 1'b0);
                chk("dn_size_r", dn_size, up_size);
                chk("dn_addr_r", dn_addr, up_addr);
            end
        end
        smp_up_req = up_req; smp_up_wr = up_wr; smp_up_size = up_size;
        smp_up_addr = up_addr; smp_up_wdata = up_wdata;
        smp_dn_addr_ok = dn_addr_ok; smp_dn_data_ok = dn_data_ok; smp_e_aok = e_aok;
        smp_up_addr_ok = up_addr_ok; smp_up_data_ok = up_data_ok; smp_up_rdata = up_rdata;
        smp_dn_req = dn_req; smp_dn_wr = dn_wr; smp_dn_size = dn_size;
        smp_dn_addr = dn_addr; smp_dn_wdata = dn_wdata;
    endtask

    task automatic model_step();
        bit wr_acc;
        wr_acc = smp_up_req && smp_up_wr && smp_e_aok;
        case (m_mode)
            M_FREE:  if (wq.size() > 0) m_mode = M_WPRES;
                     else if (smp_up_req && !smp_up_wr) m_mode = M_RPRES;
            M_WPRES: if (smp_dn_addr_ok) m_mode = M_WWAIT;
            M_WWAIT: if (smp_dn_data_ok) begin void'(wq.pop_front()); m_mode = M_FREE; end
            M_RPRES: if (!(smp_up_req && !smp_up_wr)) m_mode = M_FREE;
                     else if (smp_dn_addr_ok) m_mode = M_RWAIT;
            M_RWAIT: if (smp_dn_data_ok) m_mode = M_FREE;
            default: m_mode = M_FREE;
        endcase
        if (wr_acc) wq.push_back('{1'b1, smp_up_size, smp_up_addr, smp_up_wdata});
        m_ack = wr_acc;
    endtask

    task automatic slave_step();
        if (smp_dn_data_ok && s_busy) begin
            if (s_kwr) wdone++;
            s_busy = 1'b0;
        end else if (s_busy && s_cnt > 0) begin
            s_cnt--;
        end
        if (smp_dn_req && smp_dn_addr_ok) begin
            s_busy = 1'b1;
            s_kwr  = smp_dn_wr;
            s_cnt  = $urandom_range(s_lat_min, s_lat_max) - 1;
            dn_log.push_back('{smp_dn_wr, smp_dn_size, smp_dn_addr, smp_dn_wdata});
        end
        if (smp_up_req && smp_up_wr && smp_up_addr_ok)
            up_log.push_back('{1'b1, smp_up_size, smp_up_addr, smp_up_wdata});
    endtask

    // one clock: called at posedge+1 with upstream inputs already set
    task automatic cycle();
        slave_drive();
        #4;
        check_outputs();
        @(posedge clk);
        model_step();
        slave_step();
        #1;
    endtask

    task automatic set_up(input logic req, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        up_req = req; up_wr = wr; up_size = sz; up_addr = a; up_wdata = d;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        set_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        while ((wq.size() != 0 || m_mode != M_FREE || s_busy) && n < 300) begin
            cycle();
            n++;
        end
        chk(nm, (n < 300), 1'b1);
    endtask

    task automatic slave_cfg(input int aok, input int lmin, input int lmax);
        s_aok_pct = aok; s_lat_min = lmin; s_lat_max = lmax;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $finish;
    end

    initial begin
        int n, w0, wstart, stale;
        bit ok;
        logic [2:0] kinds;
        resetn = 1'b0;
        set_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        dn_addr_ok = 1'b0; dn_data_ok = 1'b0; dn_rdata = 32'h0;
        s_block = 1'b0; s_stray = 1'b0; s_rfix_en = 1'b0; s_rfix = 32'h0;
        s_stray_pct = 0; wdone = 0;
        slave_cfg(100, 1, 1);
        model_reset();

        // reset state, with a write request presented
        repeat (2) @(posedge clk);
        #1 set_up(1'b1, 1'b1, 2'd2, 32'h40, 32'h1);
        #3;
        chk("rst_dn_req", dn_req, 1'b0);
        chk("rst_dn_wr", dn_wr, 1'b0);
        chk("rst_up_addr_ok", up_addr_ok, 1'b0);
        chk("rst_up_data_ok", up_data_ok, 1'b0);
        chk("rst_count", dut.u_fifo.r_count, 32'd0);
        @(posedge clk);
        #3 set_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // posted write
        set_up(1'b1, 1'b1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF);
        cycle();
        chk("pw_addr_ok", smp_up_addr_ok, 1'b1);
        set_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        cycle();
        chk("pw_data_ok", smp_up_data_ok, 1'b1);
        cycle();
        chk("pw_dn_req", smp_dn_req, 1'b1);
        chk("pw_dn_wr", smp_dn_wr, 1'b1);
        chk("pw_dn_size", smp_dn_size, 2'd2);
        chk("pw_dn_addr", smp_dn_addr, 32'h0000_1000);
        chk("pw_dn_wdata", smp_dn_wdata, 32'hDEAD_BEEF);
        drain("pw_drain");

        // full: downstream blocked, 5 back-to-back writes
        s_block = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_up(1'b1, 1'b1, 2'd2, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i));
            cycle();
            chk($sformatf("full_aok%0d", i), smp_up_addr_ok, (i < 4) ? 1'b1 : 1'b0);
        end
        repeat (3) begin
            cycle();
            chk("full_hold", smp_up_addr_ok, 1'b0);
        end
        s_block = 1'b0;
        slave_cfg(100, 2, 2);
        wstart = wdone;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            w0 = wdone;
            cycle();
            if (smp_up_addr_ok) begin
                chk("full_after_pop", (w0 > wstart), 1'b1);
                ok = 1'b1;
            end
        end
        chk("full_5th_accepted", ok, 1'b1);
        drain("full_drain");

        // ordering: W, W, then a read that must wait for both writes
        slave_cfg(100, 3, 3);
        s_rfix_en = 1'b1; s_rfix = 32'h1234_5678;
        dn_log.delete();
        wstart = wdone;
        set_up(1'b1, 1'b1, 2'd2, 32'h100, 32'h1111_0001);
        cycle();
        set_up(1'b1, 1'b1, 2'd2, 32'h104, 32'h1111_0002);
        cycle();
        set_up(1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            cycle();
            if (smp_up_addr_ok) begin
                chk("ord_writes_done", wdone - wstart, 32'd2);
                ok = 1'b1;
            end
        end
        chk("ord_read_accepted", ok, 1'b1);
        set_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            if (smp_up_data_ok) begin
                chk("ord_rdata", smp_up_rdata, 32'h1234_5678);
                ok = 1'b1;
            end
        end
        chk("ord_read_done", ok, 1'b1);
        chk("ord_dn_count", dn_log.size(), 32'd3);
        if (dn_log.size() == 3) begin
            kinds = {dn_log[0].wr, dn_log[1].wr, dn_log[2].wr};
            chk("ord_seq", kinds, 3'b110);
            chk("ord_rd_addr", dn_log[2].a, 32'h0000_1000);
        end
        s_rfix_en = 1'b0;
        drain("ord_drain");

        // wrap-around: 10 writes, random latency, one byte-sized entry
        slave_cfg(70, 1, 5);
        up_log.delete(); dn_log.delete();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) set_up(1'b1, 1'b1, 2'd0, 32'h0000_0003, $urandom);
            else        set_up(1'b1, 1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom);
            ok = 1'b0;
            for (int k = 0; k < 60 && !ok; k++) begin
                cycle();
                ok = smp_up_addr_ok;
            end
            chk("wrap_accepted", ok, 1'b1);
        end
        drain("wrap_drain");
        chk("wrap_count", dn_log.size(), 32'd10);
        for (int i = 0; i < 10 && i < dn_log.size() && i < up_log.size(); i++) begin
            chk($sformatf("wrap_size%0d", i), dn_log[i].s, up_log[i].s);
            chk($sformatf("wrap_addr%0d", i), dn_log[i].a, up_log[i].a);
            chk($sformatf("wrap_data%0d", i), dn_log[i].d, up_log[i].d);
        end
        if (dn_log.size() > 3) begin
            chk("wrap_byte_size", dn_log[3].s, 2'd0);
            chk("wrap_byte_addr", dn_log[3].a, 32'h0000_0003);
        end

        // reset while a write is outstanding with 3 entries buffered
        s_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_up(1'b1, 1'b1, 2'd2, 32'h300 + 32'(4 * i), 32'hB000 + 32'(i));
            cycle();
        end
        set_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        s_block = 1'b0;
        slave_cfg(100, 5, 5);
        cycle();
        chk("rst_pre_cnt", dut.u_fifo.r_count, 32'd3);
        set_up(1'b1, 1'b1, 2'd2, 32'h400, 32'hC);
        dn_addr_ok = 1'b0; dn_data_ok = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_dn_req", dn_req, 1'b0);
        chk("mid_rst_up_addr_ok", up_addr_ok, 1'b0);
        chk("mid_rst_up_data_ok", up_data_ok, 1'b0);
        model_reset();
        @(posedge clk);
        #2 set_up(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        resetn = 1'b1;
        #1 chk("mid_rst_count", dut.u_fifo.r_count, 32'd0);
        @(posedge clk);
        #1;
        slave_cfg(100, 1, 3);
        stale = 0;
        repeat (15) begin
            cycle();
            if (smp_dn_req) stale++;
        end
        chk("mid_rst_no_stale", stale, 32'd0);

        // stray downstream response while idle
        s_stray = 1'b1;
        cycle();
        chk("stray_data_ok", smp_up_data_ok, 1'b0);
        s_stray = 1'b0;
        cycle();
        chk("stray_count", dut.u_fifo.r_count, 32'd0);

        // randomised traffic
        slave_cfg(60, 1, 5);
        s_stray_pct = 3;
        for (int c = 0; c < 3000; c++) begin
            if (!u_has && !u_wait && $urandom_range(0, 99) < 60) begin
                u_has = 1'b1;
                u_wr  = ($urandom_range(0, 99) < 75);
                set_up(1'b1, u_wr, 2'($urandom_range(0, 2)), $urandom, $urandom);
            end else if (u_has && !u_wr && $urandom_range(0, 99) < 5) begin
                u_has = 1'b0;
            end
            if (!u_has) set_up(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            cycle();
            if (u_wait) begin
                u_wt++;
                if (smp_up_data_ok || u_wt > 100) u_wait = 1'b0;
            end
            if (u_has && smp_up_addr_ok) begin
                if (!u_wr) begin u_wait = 1'b1; u_wt = 0; end
                u_has = 1'b0;
            end
        end
        s_stray_pct = 0;
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_write_buffer.md
D_WRITE_BUFFER -- requirements
Module: d_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of posted-write entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, meaning the address and data width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port resetn  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have upstream ports from the d-cache: up_req in 1, up_wr in 1, up_size in 2, up_addr in 32, up_wdata in 32, up_rdata out 32, up_addr_ok out 1, up_data_ok out 1; all use sram-like semantics.
REQ-006 SHALL have downstream ports to the AXI bridge: dn_req out 1, dn_wr out 1, dn_size out 2, dn_addr out 32, dn_wdata out 32, dn_rdata in 32, dn_addr_ok in 1, dn_data_ok in 1.

Function
REQ-007 SHALL treat an upstream request as accepted in a cycle where up_req and up_addr_ok are both 1.
REQ-008 SHALL, for an upstream write, assert up_addr_ok iff the FIFO is not full, with full taken from the registered count and no same-cycle pop bypass.
REQ-009 SHALL push {up_size, up_addr, up_wdata} on write acceptance and assert up_data_ok exactly one cycle later (registered), independent of the downstream side.
REQ-010 SHALL keep DEPTH entries with wrap-around read/write pointers and a count of width log2(DEPTH)+1; full is count==DEPTH, empty is count==0.
REQ-011 SHALL use a drain FSM with states IDLE, WREQ, WWAIT, RREQ and RWAIT, and allow only one downstream transaction outstanding.
REQ-012 SHALL, in IDLE, go to WREQ if the FIFO is non-empty; otherwise go to RREQ if up_req&~up_wr; otherwise stay in IDLE. Draining has priority over reads.
REQ-013 SHALL, in WREQ, drive dn_req=1, dn_wr=1 and dn_size/addr/wdata from the FIFO head, and go to WWAIT on dn_addr_ok.
REQ-014 SHALL, in WWAIT, drive dn_req=0; on dn_data_ok it SHALL pop the head and return to IDLE.
REQ-015 SHALL stall an upstream read (up_addr_ok=0) while the FIFO is non-empty or a write is in WREQ/WWAIT, for strict write-before-read ordering.
REQ-016 SHALL, in RREQ, pass up_size/up_addr through with dn_wr=0, dn_req=up_req&~up_wr and up_addr_ok=dn_addr_ok, then go to RWAIT on acceptance; if up_req drops it SHALL return to IDLE.
REQ-017 SHALL, in RWAIT, drive up_rdata=dn_rdata and up_data_ok=dn_data_ok combinationally, then return to IDLE on dn_data_ok.
REQ-018 SHALL accept no upstream write while in RREQ/RWAIT (up_addr_ok=0).
REQ-019 SHALL allow a push and a pop in the same cycle; the count is unchanged and the entry contents stay intact.
REQ-020 SHALL ignore dn_data_ok in IDLE, WREQ and RREQ: no pop and no upstream response.
REQ-021 SHALL drive up_rdata=0 outside RWAIT.
REQ-022 SHALL make dn_req, up_addr_ok and up_data_ok glitch-free functions of the registered state and the current inputs only.

Reset
REQ-023 SHALL, while resetn=0, force state=IDLE, pointers=0, count=0 and the registered up_data_ok=0; outputs SHALL read dn_req=0, dn_wr=0, up_addr_ok=0 and up_data_ok=0.
REQ-024 SHALL discard buffered entries and any outstanding downstream transaction when reset is asserted mid-operation; the downstream bridge is reset by the same resetn.
REQ-025 SHALL leave FIFO storage RAM uninitialised; only the control state is reset.

Structure
REQ-026 SHALL place the FSM state encodings (3-bit) and the entry width constant (66) in the shared memory-path header used by the d-cache and bridge.
REQ-027 SHALL implement the storage as one sub-module, wbuf_fifo, providing push/pop/full/empty/head, parameterised on DEPTH and width.

Verification
REQ-028 SHALL cover posted write: write addr 0x0000_1000 data 0xDEAD_BEEF size 2 -> up_addr_ok same cycle, up_data_ok next cycle; dn_req/dn_wr with the same addr/data within 2 cycles.
REQ-029 SHALL cover full: with dn_addr_ok held 0, 5 back-to-back writes -> the first 4 are accepted and the 5th sees up_addr_ok=0 until the first dn_data_ok pop.
REQ-030 SHALL cover ordering: 2 writes then a read of 0x0000_1000 -> the read is stalled until both dn_data_ok are seen; the downstream order is W,W,R and up_rdata equals the dn_rdata value 0x1234_5678.
REQ-031 SHALL cover wrap-around: 10 writes with random downstream latency 1..5 -> the downstream sequence matches the upstream sequence exactly, byte sizes included (size 0, addr 0x3).
REQ-032 SHALL cover reset mid-drain: resetn low while in WWAIT with 3 entries -> dn_req=0 immediately (asynchronous), count=0 after release, and no stale write is issued.
REQ-033 SHALL cover stray response: dn_data_ok pulse in IDLE with an empty FIFO -> no up_data_ok and the count stays 0.
